// File: rtl/mixer_lo_sequencer_if.sv
// Configuration handshake between the control plane and the LO sequencer.
// The control plane drives the request as master; the sequencer answers with cfg_ready.
interface mixer_lo_sequencer_if #(
   parameter int unsigned PHASE_W = 16
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic               cfg_enable;
   logic [PHASE_W-1:0] cfg_step;
   logic [PHASE_W-1:0] cfg_phase;

   modport master (
      output cfg_valid, cfg_enable, cfg_step, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_enable, cfg_step, cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/mixer_lo_sequencer.sv
// Tri-level quadrature LO sequencer: an NCO decoded into {+1, 0, -1} I/Q codes for the mixer.
// Retunes and stops requested while running are deferred to the next phase wrap.
module mixer_lo_sequencer #(
   parameter int unsigned PHASE_W = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         sample_en_i,
   mixer_lo_sequencer_if.slave          cfg,
   output logic [1:0]                   lo_i_o,
   output logic [1:0]                   lo_q_o,
   output logic                         wrap_o,
   output logic                         running_o
);

   typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

   state_e             state_q;
   logic [PHASE_W-1:0] acc_q;
   logic [PHASE_W-1:0] step_q;
   logic [PHASE_W-1:0] pend_step_q;
   logic               pend_en_q;
   logic [1:0]         lo_i_q;
   logic [1:0]         lo_q_q;
   logic               wrap_q;
   logic               running_q;

   logic [PHASE_W:0]   sum;
   logic               carry;
   logic               pend_fire;

   // Codes: 01 = +1, 10 = -1, 00 = 0, selected by the top three phase bits.
   function automatic logic [1:0] cos_code(input logic [PHASE_W-1:0] phase);
      logic [2:0] oct;
      oct = phase[PHASE_W-1 -: 3];
      case (oct)
         3'd7, 3'd0: cos_code = 2'b01;
         3'd3, 3'd4: cos_code = 2'b10;
         default:    cos_code = 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] sin_code(input logic [PHASE_W-1:0] phase);
      logic [2:0] oct;
      oct = phase[PHASE_W-1 -: 3];
      case (oct)
         3'd1, 3'd2: sin_code = 2'b01;
         3'd5, 3'd6: sin_code = 2'b10;
         default:    sin_code = 2'b00;
      endcase
   endfunction

   always_comb begin
      sum       = {1'b0, acc_q} + {1'b0, step_q};
      carry     = sum[PHASE_W];
      // A zero step never wraps, so the pending config must not wait for one.
      pend_fire = carry || (step_q == '0);
      cfg.cfg_ready = (state_q != StPend);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         step_q      <= '0;
         pend_step_q <= '0;
         pend_en_q   <= 1'b0;
         lo_i_q      <= 2'b00;
         lo_q_q      <= 2'b00;
         wrap_q      <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cfg.cfg_valid && cfg.cfg_enable) begin
                  acc_q     <= cfg.cfg_phase;
                  step_q    <= cfg.cfg_step;
                  lo_i_q    <= cos_code(cfg.cfg_phase);
                  lo_q_q    <= sin_code(cfg.cfg_phase);
                  running_q <= 1'b1;
                  state_q   <= StRun;
               end
            end
            StRun: begin
               if (sample_en_i) begin
                  acc_q  <= sum[PHASE_W-1:0];
                  lo_i_q <= cos_code(sum[PHASE_W-1:0]);
                  lo_q_q <= sin_code(sum[PHASE_W-1:0]);
                  wrap_q <= carry;
               end
               if (cfg.cfg_valid) begin
                  pend_step_q <= cfg.cfg_step;
                  pend_en_q   <= cfg.cfg_enable;
                  state_q     <= StPend;
               end
            end
            StPend: begin
               if (sample_en_i) begin
                  acc_q  <= sum[PHASE_W-1:0];
                  lo_i_q <= cos_code(sum[PHASE_W-1:0]);
                  lo_q_q <= sin_code(sum[PHASE_W-1:0]);
                  wrap_q <= carry;
                  if (pend_fire) begin
                     if (pend_en_q) begin
                        step_q  <= pend_step_q;
                        state_q <= StRun;
                     end else begin
                        lo_i_q    <= 2'b00;
                        lo_q_q    <= 2'b00;
                        running_q <= 1'b0;
                        state_q   <= StIdle;
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign lo_i_o    = lo_i_q;
   assign lo_q_o    = lo_q_q;
   assign wrap_o    = wrap_q;
   assign running_o = running_q;

endmodule

// File: doc/mixer_lo_sequencer.md
# mixer_lo_sequencer

Tri-level quadrature local-oscillator sequencer that drives the `LO_i`/`LO_q` select inputs of the IQ mixer.
- A phase accumulator (NCO) advances once per accepted sample and is decoded into {+1, 0, −1} codes for the I and Q branches.
- A valid/ready configuration port lets the control plane start, stop and retune the LO.
- Frequency changes while running take effect only at a phase wrap, so retuning never glitches the mixer.
- Sits between the control registers and the mixer, sharing the mixer's clock.

## Interface
Parameters:
- PHASE_W, 16, phase accumulator width (≥ 4).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_en  in  1  advance strobe; accumulator steps only when high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when valid && ready at clock edge.
- cfg_enable  in  1  1 = run LO, 0 = stop (LO forced to zero).
- cfg_step  in  PHASE_W  phase increment per sample (unsigned).
- cfg_phase  in  PHASE_W  start phase, used only when starting from IDLE.
- LO_i  out  2  I-branch code: 01 = +1, 10 = −1, 00 = 0 (11 never emitted).
- LO_q  out  2  Q-branch code, same encoding.
- wrap  out  1  one-cycle pulse when the accumulator overflows.
- running  out  1  high in RUN and PEND.

## Operation
- State: acc[PHASE_W-1:0], step_r, pend_step, pend_en; FSM states IDLE, RUN, PEND.
- Decode uses octant p = acc[PHASE_W-1:PHASE_W-3].
  - cos code: p ∈ {7,0} → 01; {3,4} → 10; {1,2,5,6} → 00.
  - sin code: p ∈ {1,2} → 01; {5,6} → 10; {3,4,7,0} → 00.
  - LO_i = cos(acc), LO_q = sin(acc).
- IDLE:
  - cfg_ready = 1; LO_i = LO_q = 00; acc held.
  - Accept with cfg_enable = 1: acc ← cfg_phase, step_r ← cfg_step, LO ← decode(cfg_phase); go to RUN.
  - Accept with cfg_enable = 0: stay in IDLE, no change.
- RUN:
  - cfg_ready = 1.
  - On sample_en: {carry, acc} ← acc + step_r; LO ← decode(new acc); wrap ← carry.
  - Accept: pend_step ← cfg_step, pend_en ← cfg_enable; go to PEND. cfg_phase is ignored.
- PEND:
  - cfg_ready = 0; accumulator keeps stepping with the old step_r.
  - On a sample_en edge that produces a carry, or any sample_en edge when step_r == 0:
    - If pend_en = 1: step_r ← pend_step; go to RUN. The wrapped acc is kept; the new step applies from the next sample.
    - If pend_en = 0: LO ← 00/00; go to IDLE. acc keeps the wrapped value.
- Arithmetic is modulo 2^PHASE_W; the carry is the overflow bit of the PHASE_W+1-bit sum.
- A config accept and a sample_en on the same RUN edge both take effect: the step advances with the old step_r and the FSM enters PEND.
- Reset:
  - state = IDLE; acc, step_r, pend_* = 0.
  - LO_i = LO_q = 00; wrap = 0; running = 0; cfg_ready = 1 from the first post-reset cycle.
  - Reset mid-PEND discards the pending config.

## Timing
- All outputs are registered except cfg_ready, which is a combinational decode of the FSM state.
- LO codes change on the same edge as acc; the mixer product appears one further cycle later.
- wrap pulses in the cycle following the overflowing edge, for exactly one cycle, and only when sample_en was high.
- Start latency: the accept edge sets LO = decode(cfg_phase); the first step occurs on the next sample_en edge.
- Retune latency: from PEND entry up to 2^PHASE_W / step_r samples (until the wrap).
- running tracks the state: high on the edge entering RUN, low on the edge entering IDLE.
- sample_en low freezes acc, LO and the PEND condition indefinitely.

## Test plan
- Reset: after reset, LO_i = LO_q = 00, wrap = 0, running = 0, cfg_ready = 1; sample_en toggling causes no change.
- fs/4 run: start with step = 0x4000, phase = 0x0000, sample_en = 1 continuously.
  - LO_i/LO_q sequence per cycle: 01/00, 00/01, 10/00, 00/10, repeating.
  - wrap pulses every 4th sample, coincident with the return to 01/00.
- Phase start: start with phase = 0x8000, step = 0x2000. First LO_i = 10, then the octant advances by one per sample, with codes matching the decode table.
- Retune at wrap: running step = 0x4000, accept step = 0x2000 mid-cycle.
  - cfg_ready drops to 0 and the old step continues until the wrap.
  - After the wrap, the octant advances by 1 per sample; cfg_ready returns to 1.
- Stop at wrap: in RUN, accept enable = 0. LO continues until the next wrap, then goes to 00/00, state IDLE, running = 0.
- Edge cases:
  - step = 0 in PEND: the pending config applies on the next sample_en.
  - sample_en held low for 10 cycles in PEND: no transition occurs.
  - Reset asserted in PEND: IDLE, outputs zero.
